seq_match_ctrl: RTL and testbench
=================================

Name: seq_match_ctrl

Overview:
- Controller that sequences a 16-bit word-serial pattern detector.
- Accepts a word and pattern configuration over a valid/ready handshake, shifts the word MSB-first one bit per clock, and detects a programmable pattern of up to PAT_W bits, overlaps allowed.
- Returns per-word match count and match-position mask over a second valid/ready handshake.
- Sits between the word producer and the match consumer; replaces the free-running load-once detector.

Parameters:
- WORD_W, 16, input word width; bits processed MSB first.
- PAT_W, 4, maximum pattern length.
- CNT_W, 5, match counter width; must hold WORD_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  word offer.
- in_ready  out  1  high only in IDLE.
- in_data  in  WORD_W  word to scan.
- pat  in  PAT_W  pattern; the low pat_len bits are used, the oldest bit is the highest used bit.
- pat_len  in  $clog2(PAT_W+1)  pattern length; 0 means never match; values above PAT_W clamp to PAT_W.
- bit_out  out  1  bit consumed on the previous shift edge (registered).
- match  out  1  one-cycle pulse, registered with bit_out, when that bit completes the pattern.
- busy  out  1  state is SHIFT.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- match_cnt  out  CNT_W  matches in the word.
- match_pos  out  WORD_W  bit j set if a match ended on in_data[j].

Behaviour:
- Reset values: state IDLE, in_ready 1, bit_out 0, match 0, busy 0, out_valid 0, match_cnt 0, match_pos 0. History register and history-valid count are cleared.
- Reset asserted mid-operation aborts the current word; that word is discarded and no result is produced.
- FSM states:
  - IDLE: accepts when in_valid and in_ready are both high. On accept it latches in_data into the shift register, latches pat and pat_len (later input changes are ignored for this word), clears the bit index, match_cnt and match_pos, clears the history (see Optional Feature), then moves to SHIFT.
  - SHIFT: each edge consumes the MSB of the shift register and shifts the register left by 1. The history register takes {hist, bit}; the history-valid count hcnt saturates at PAT_W. A match occurs when pat_len != 0, hcnt+1 >= pat_len, and the low pat_len bits of {hist, bit} equal the low pat_len bits of pat. On a match, match_cnt increments and match_pos[WORD_W-1-k] is set, where k = 0..WORD_W-1 is the consumed-bit index. After the WORD_W-th bit the FSM moves to DONE.
  - DONE: out_valid is 1; match_cnt and match_pos are held stable. When out_valid and out_ready are both high at an edge, the FSM returns to IDLE. There is no bypass: in_ready rises the cycle after the result handshake.
- Latency and throughput:
  - Accept at edge E0; bits are consumed at E1..E16; out_valid is high after E16.
  - The last match pulse coincides with out_valid rising.
  - Minimum of WORD_W+2 cycles per word.
- Boundary conditions:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
  - Up to WORD_W matches per word with pat_len=1; no counter overflow at CNT_W=5.

Optional Feature:
- Macro: SEQ_CARRY_EN.
- Defined: history and hcnt carry across words, so a pattern spanning a word boundary is detected. Such a match is counted in, and positioned within, the new word. History is cleared only on reset, or on accept when the new pat/pat_len differs from the previously latched values.
- Undefined: history and hcnt are cleared on every accept; matches never span words.

Test Plan:
- in_data=16'hD000, pat=4'b1101, pat_len=4 -> single match pulse on the 4th shift cycle; match_cnt=1; match_pos=16'h1000; out_valid 16 cycles after accept.
- Overlap: in_data=16'hDB60, pat=1101, pat_len=4 -> match_cnt=3; match_pos=16'h1240; bit_out sequence 1101101101100000.
- in_data=16'hFFFF, pat=4'b0001, pat_len=1 -> match_cnt=16, match_pos=16'hFFFF. Same word with pat_len=0 -> match_cnt=0, match_pos=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1; match_cnt and match_pos unchanged; in_ready=0; an in_valid pulse is not accepted. Then raise out_ready -> IDLE next cycle.
- Assert rst after 5 shift cycles -> all outputs at their reset values immediately. The next word, 16'hD000, gives match_cnt=1 with no residue from the aborted word.
- Carry: word1=16'h0003, then word2=16'h4000, pat=1101, pat_len=4.
  - With SEQ_CARRY_EN: word2 match_cnt=1, match_pos=16'h4000.
  - Without SEQ_CARRY_EN: word2 match_cnt=0.

Source files
------------

// File: rtl/seq_match_if.sv
// Handshake and result bundle for seq_match_ctrl.
// master: word producer / result consumer side. slave: the controller.
interface seq_match_if #(
  parameter int WORD_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic [PAT_W-1:0]  pat;
  logic [LEN_W-1:0]  pat_len;
  logic              bit_out;
  logic              match;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  match_cnt;
  logic [WORD_W-1:0] match_pos;

  modport master (
    output in_valid, in_data, pat, pat_len, out_ready,
    input  in_ready, bit_out, match, busy, out_valid, match_cnt, match_pos
  );

  modport slave (
    input  in_valid, in_data, pat, pat_len, out_ready,
    output in_ready, bit_out, match, busy, out_valid, match_cnt, match_pos
  );
endinterface

// File: rtl/seq_match_ctrl.sv
// Word-serial pattern detector controller. A word is accepted in IDLE,
// shifted out MSB-first in SHIFT (one bit per clock, overlapping matches
// counted), and the count/position mask is offered in DONE until taken.
// Optional build macro SEQ_CARRY_EN: keep bit history across words so a
// pattern spanning a word boundary is detected (history cleared only on
// reset or when the latched pattern/length changes).
module seq_match_ctrl #(
  parameter int WORD_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5
) (
  input logic       clk,
  input logic       rst,
  seq_match_if.slave bus
);
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int IDX_W = $clog2(WORD_W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] pos_q, pos_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [LEN_W-1:0]  hcnt_q, hcnt_d;
  logic              bit_q, bit_d;
  logic              match_q, match_d;

  logic [LEN_W-1:0]  len_clamp;
  logic              cur_bit;
  logic [PAT_W-1:0]  win;
  logic [PAT_W-1:0]  mask;
  logic [LEN_W:0]    hcnt_next;
  logic              hit;

  // Next-state, datapath update and match evaluation.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    pat_d     = pat_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    hist_d    = hist_q;
    hcnt_d    = hcnt_q;
    bit_d     = bit_q;
    match_d   = 1'b0;

    len_clamp = (bus.pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.pat_len;
    cur_bit   = sh_q[WORD_W-1];
    // Newest bit lands in position 0; the oldest used bit sits at len-1.
    win       = PAT_W'({hist_q, cur_bit});
    mask      = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    hcnt_next = {1'b0, hcnt_q} + (LEN_W+1)'(1);
    hit       = (len_q != '0) && (hcnt_next >= {1'b0, len_q}) &&
                (((win ^ pat_q) & mask) == '0);

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sh_d  = bus.in_data;
          pat_d = bus.pat;
          len_d = len_clamp;
          idx_d = '0;
          cnt_d = '0;
          pos_d = '0;
`ifdef SEQ_CARRY_EN
          if ((bus.pat != pat_q) || (len_clamp != len_q)) begin
            hist_d = '0;
            hcnt_d = '0;
          end
`else
          hist_d = '0;
          hcnt_d = '0;
`endif
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sh_d    = sh_q << 1;
        hist_d  = win;
        hcnt_d  = (hcnt_q == LEN_W'(PAT_W)) ? hcnt_q : hcnt_next[LEN_W-1:0];
        bit_d   = cur_bit;
        match_d = hit;
        if (hit) begin
          cnt_d = cnt_q + CNT_W'(1);
          pos_d[IDX_W'(WORD_W-1) - idx_q] = 1'b1;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(WORD_W-1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control, history and result registers; reset aborts any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      hist_q  <= '0;
      hcnt_q  <= '0;
      bit_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      hist_q  <= hist_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      match_q <= match_d;
    end
  end

  // Word and pattern holding registers; only meaningful after an accept.
  always_ff @(posedge clk) begin
    sh_q  <= sh_d;
    pat_q <= pat_d;
    len_q <= len_d;
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_SHIFT);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.bit_out   = bit_q;
  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.match_pos = pos_q;
endmodule

// File: tb/tb_seq_match_ctrl.sv
// Testbench for seq_match_ctrl: table of directed words, hand-written
// reset/carry sequences, and random words against a bit-stream model.
module tb_seq_match_ctrl;
  logic clk;
  logic rst;

  seq_match_if #(.WORD_W(16), .PAT_W(4), .CNT_W(5)) bus ();

  seq_match_ctrl #(.WORD_W(16), .PAT_W(4), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model state: the recent consumed bits, newest at the back.
  bit         stream[$];
  logic [3:0] last_pat = 4'd0;
  int         last_len = -1;
  logic       exp_m[16];
  logic [4:0] exp_cnt;
  logic [15:0] exp_pos;

  typedef struct {
    logic [15:0] w;
    logic [3:0]  p;
    logic [2:0]  l;
    int          hold;
    logic [4:0]  cnt;
    logic [15:0] pos;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scan the word as a bit stream: a match is when the last L bits seen
  // equal pat[L-1:0] with pat[0] being the newest bit.
  task automatic model_word(input logic [15:0] w, input logic [3:0] p, input logic [2:0] l);
    int  L;
    bit  hit;
    L = (l > 3'd4) ? 4 : int'(l);
`ifdef SEQ_CARRY_EN
    if (p != last_pat || L != last_len) stream.delete();
`else
    stream.delete();
`endif
    last_pat = p;
    last_len = L;
    exp_cnt  = '0;
    exp_pos  = '0;
    for (int k = 0; k < 16; k++) begin
      stream.push_back(w[15-k]);
      if (stream.size() > 4) void'(stream.pop_front());
      hit = (L > 0) && (stream.size() >= L);
      for (int i = 0; i < L; i++) begin
        if (hit && stream[stream.size()-1-i] != p[i]) hit = 1'b0;
      end
      exp_m[k] = hit;
      if (hit) begin
        exp_cnt       = exp_cnt + 5'd1;
        exp_pos[15-k] = 1'b1;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_bit_out"},   32'(bus.bit_out),   32'd0);
    check({tag, "_match"},     32'(bus.match),     32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_match_cnt"}, 32'(bus.match_cnt), 32'd0);
    check({tag, "_match_pos"}, 32'(bus.match_pos), 32'd0);
  endtask

  // Offer one word, follow it bit by bit, hold the result for 'hold'
  // cycles of backpressure, then take it.
  task automatic run_word(input logic [15:0] w, input logic [3:0] p, input logic [2:0] l,
                          input int hold, output logic [4:0] got_cnt, output logic [15:0] got_pos);
    int t;
    logic [15:0] bits;
    model_word(w, p, l);
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    bus.pat      = p;
    bus.pat_len  = l;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    bus.pat      = 4'($urandom);
    bus.pat_len  = 3'($urandom);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("in_ready_shift", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      bits[15-k] = bus.bit_out;
      check("match_pulse", 32'(bus.match), 32'(exp_m[k]));
      check("out_valid_timing", 32'(bus.out_valid), 32'(k == 15));
    end
    check("bit_out_seq", 32'(bits), 32'(w));
    check("match_cnt", 32'(bus.match_cnt), 32'(exp_cnt));
    check("match_pos", 32'(bus.match_pos), 32'(exp_pos));
    check("busy_done", 32'(bus.busy), 32'd0);
    got_cnt = bus.match_cnt;
    got_pos = bus.match_pos;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = (h == 2);
      @(posedge clk); #1;
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_cnt", 32'(bus.match_cnt), 32'(exp_cnt));
      check("hold_pos", 32'(bus.match_pos), 32'(exp_pos));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_match", 32'(bus.match), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  gc;
    logic [15:0] gp;
    logic [15:0] w;
    logic [3:0]  p;
    logic [2:0]  l;

    tbl[0] = '{16'hD000, 4'b1101, 3'd4, 0,  5'd1,  16'h1000};
    tbl[1] = '{16'hDB60, 4'b1101, 3'd4, 0,  5'd3,  16'h1240};
    tbl[2] = '{16'hFFFF, 4'b0001, 3'd1, 0,  5'd16, 16'hFFFF};
    tbl[3] = '{16'hFFFF, 4'b0001, 3'd0, 0,  5'd0,  16'h0000};
    tbl[4] = '{16'hD000, 4'b1101, 3'd4, 10, 5'd1,  16'h1000};
    tbl[5] = '{16'hD000, 4'b1101, 3'd7, 3,  5'd1,  16'h1000};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.pat       = '0;
    bus.pat_len   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    stream.delete();
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_word(tbl[i].w, tbl[i].p, tbl[i].l, tbl[i].hold, gc, gp);
      check("tbl_cnt", 32'(gc), 32'(tbl[i].cnt));
      check("tbl_pos", 32'(gp), 32'(tbl[i].pos));
    end

    // Reset during SHIFT discards the word.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    bus.pat      = 4'b0001;
    bus.pat_len  = 3'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    stream.delete();
    @(posedge clk); #1;
    check("midreset_no_result", 32'(bus.out_valid), 32'd0);
    run_word(16'hD000, 4'b1101, 3'd4, 0, gc, gp);
    check("after_reset_cnt", 32'(gc), 32'd1);
    check("after_reset_pos", 32'(gp), 32'h1000);

    // Pattern spanning a word boundary.
    run_word(16'h0003, 4'b1101, 3'd4, 0, gc, gp);
    check("carry_w1_cnt", 32'(gc), 32'd0);
    run_word(16'h4000, 4'b1101, 3'd4, 0, gc, gp);
`ifdef SEQ_CARRY_EN
    check("carry_w2_cnt", 32'(gc), 32'd1);
    check("carry_w2_pos", 32'(gp), 32'h4000);
`else
    check("carry_w2_cnt", 32'(gc), 32'd0);
    check("carry_w2_pos", 32'(gp), 32'h0000);
`endif

    // Random words; half the time the pattern is kept to exercise carry.
    p = 4'b1011;
    l = 3'd3;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(1, 0) == 0) begin
        p = 4'($urandom);
        l = 3'($urandom);
      end
      w = 16'($urandom);
      run_word(w, p, l, int'($urandom_range(3, 0)), gc, gp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
